// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI types (mode word, transaction FSM states) used by
//                the monarch RTL and by serf-side models.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // {CPOL, CPHA} as presented on the mode port
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Transaction phases: idle, pre-first-edge, edge train, post-last-edge hold
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRONT = 2'd1,
        ST_SHFT  = 2'd2,
        ST_BACK  = 2'd3
    } spi_state_t;

    // Latched mode after reset; makes SCLK idle high out of reset
    localparam spi_mode_t C_MODE_RST = '{cpol: 1'b1, cpha: 1'b1};

    // Width of a select index; never narrower than one bit
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sclk_gen
//  Description : SCLK divider and edge counter. Produces SCLK plus strobes
//                that fire in the cycle before each SCLK edge becomes visible.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,       // accepted start: restart counters
    input  logic i_start_cpol,  // CPOL of the transaction being accepted
    input  logic i_cpol,        // latched CPOL, idle level between transactions
    input  logic i_run,         // transaction in progress
    output logic o_sclk,
    output logic o_lead,        // next edge is a leading edge
    output logic o_trail,       // next edge is a trailing edge
    output logic o_last_edge,   // next edge is edge 2*DATA_W
    output logic o_end          // BACK hold expires at the next clk edge
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    localparam logic [DIV_W-1:0]  C_H_M1     = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [EDGE_W-1:0] C_EDGES    = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0] C_EDGES_M1 = EDGE_W'(2 * DATA_W - 1);

    logic [DIV_W-1:0]  r_div;
    logic [EDGE_W-1:0] r_edge;
    logic              r_sclk;
    logic              w_tick;
    logic              w_edge;

    // A tick marks the end of each half SCLK period
    assign w_tick = i_run && (r_div == C_H_M1);
    // Ticks after the final edge only time the BACK hold
    assign w_edge = w_tick && (r_edge != C_EDGES);

    // Half-period divider, restarted on every accepted transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (i_start) begin
            r_div <= '0;
        end else if (i_run) begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    // Edge counter and SCLK level; SCLK rests at CPOL outside transactions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge <= '0;
            r_sclk <= 1'b1;
        end else if (i_start) begin
            r_edge <= '0;
            r_sclk <= i_start_cpol;
        end else if (w_edge) begin
            r_edge <= r_edge + EDGE_W'(1);
            r_sclk <= ~r_sclk;
        end else if (!i_run) begin
            r_sclk <= i_cpol;
        end
    end

    assign o_sclk      = r_sclk;
    assign o_lead      = w_edge && !r_edge[0];
    assign o_trail     = w_edge &&  r_edge[0];
    assign o_last_edge = w_tick && (r_edge == C_EDGES_M1);
    assign o_end       = w_tick && (r_edge == C_EDGES);

endmodule
`default_nettype wire

// File: rtl/spi_mnrch_param.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mnrch_param
//  Description : Parameterised SPI monarch. One-word transactions in any of
//                the four SPI modes, with one-hot-low serf select decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_mnrch_param
    import spi_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  CLK_DIV = 16,
    parameter int  NUM_SS  = 1,
    localparam int SS_W    = sel_width(NUM_SS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt,
    input  logic [DATA_W-1:0] wt_data,
    input  logic [1:0]        mode,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data
);

    spi_state_t        r_state;
    spi_state_t        w_state_nxt;
    spi_mode_t         r_mode;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_rd;
    logic [NUM_SS-1:0] r_ss_n;
    logic [NUM_SS-1:0] w_ss_dec;
    logic              r_miso_s;
    logic              r_lead_d;
    logic              r_trail_d;
    logic              r_first_d;
    logic              r_last_d;
    logic              r_busy;
    logic              r_done;

    logic w_accept;
    logic w_run;
    logic w_lead;
    logic w_trail;
    logic w_last_edge;
    logic w_end;
    logic w_sample;
    logic w_shift;

    assign w_accept = wrt && (r_state == ST_IDLE);
    assign w_run    = (r_state != ST_IDLE);

    spi_sclk_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_accept),
        .i_start_cpol (mode[1]),
        .i_cpol       (r_mode.cpol),
        .i_run        (w_run),
        .o_sclk       (SCLK),
        .o_lead       (w_lead),
        .o_trail      (w_trail),
        .o_last_edge  (w_last_edge),
        .o_end        (w_end)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; phases advance on divider strobes
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)    w_state_nxt = ST_FRONT;
            ST_FRONT: if (w_lead)      w_state_nxt = ST_SHFT;
            ST_SHFT:  if (w_last_edge) w_state_nxt = ST_BACK;
            ST_BACK:  if (w_end)       w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Mode is frozen for the whole transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= C_MODE_RST;
        end else if (w_accept) begin
            r_mode <= spi_mode_t'(mode);
        end
    end

    // Delay edge strobes so data moves in the cycle after SCLK has moved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lead_d  <= 1'b0;
            r_trail_d <= 1'b0;
            r_first_d <= 1'b0;
            r_last_d  <= 1'b0;
        end else begin
            r_lead_d  <= w_lead;
            r_trail_d <= w_trail;
            r_first_d <= w_lead && (r_state == ST_FRONT);
            r_last_d  <= w_last_edge;
        end
    end

    // CPHA=0 samples on leading and shifts on trailing (not the last one);
    // CPHA=1 shifts on leading (not the first one) and samples on trailing
    assign w_sample = r_mode.cpha ? r_trail_d : r_lead_d;
    assign w_shift  = r_mode.cpha ? (r_lead_d && !r_first_d)
                                  : (r_trail_d && !r_last_d);

    // Shift register: the sampled MISO bit enters the LSB as the word moves left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_miso_s <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift <= wt_data;
            end else if (w_shift) begin
                r_shift <= {r_shift[DATA_W-2:0], r_miso_s};
            end
            if (w_sample) begin
                r_miso_s <= MISO;
            end
        end
    end

    // Select decode; an out-of-range index leaves every select inactive
    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            w_ss_dec[i] = (ss_sel != SS_W'(i));
        end
    end

    // Select outputs: asserted from cycle 1 until the transaction completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_n <= '1;
        end else if (w_accept) begin
            r_ss_n <= w_ss_dec;
        end else if (r_state == ST_BACK && w_end) begin
            r_ss_n <= '1;
        end
    end

    // Busy/done handshake and received-word capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_rd   <= '0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_state == ST_BACK && w_end) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_rd   <= {r_shift[DATA_W-2:0], r_miso_s};
        end
    end

    assign MOSI    = r_shift[DATA_W-1];
    assign SS_n    = r_ss_n;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_data = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_spi_mnrch_param.sv
`timescale 1ns/1ps
module tb_spi_mnrch_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] wt_data = '0;
    logic [1:0]  mode = 2'b00;
    logic [1:0]  ss_sel = 2'd0;
    wire         MISO;
    wire         SCLK, MOSI, busy, done;
    wire  [3:0]  SS_n;
    wire  [15:0] rd_data;

    logic        wrt2 = 1'b0;
    logic [7:0]  wt2 = '0;
    logic [1:0]  mode2 = 2'b00;
    logic [1:0]  sel2 = 2'd0;
    wire         SCLK2, MOSI2, busy2, done2;
    wire  [2:0]  SS_n2;
    wire  [7:0]  rd2;

    spi_mnrch_param #(.DATA_W(16), .CLK_DIV(16), .NUM_SS(4)) dut (
        .clk(clk), .rst_n(rst_n), .wrt(wrt), .wt_data(wt_data), .mode(mode),
        .ss_sel(ss_sel), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
        .busy(busy), .done(done), .rd_data(rd_data));

    spi_mnrch_param #(.DATA_W(8), .CLK_DIV(4), .NUM_SS(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .wrt(wrt2), .wt_data(wt2), .mode(mode2),
        .ss_sel(sel2), .MISO(MOSI2), .SCLK(SCLK2), .MOSI(MOSI2), .SS_n(SS_n2),
        .busy(busy2), .done(done2), .rd_data(rd2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int t0 = 0;
    logic [15:0] sb_q[$];
    logic [7:0]  sb2_q[$];

    // Serf model: mode-aware shift register, watched at negedges
    logic [1:0]  s_mode = 2'b11;
    logic [15:0] s_word = '0;
    logic [15:0] s_sh = '0;
    logic [15:0] s_rx = '0;
    logic        s_first = 1'b0;
    logic        s_act_q = 1'b0;
    logic        s_sclk_q = 1'b1;
    wire         s_act = ~&SS_n;
    assign MISO = s_sh[15];

    always @(negedge clk) begin
        s_act_q  <= s_act;
        s_sclk_q <= SCLK;
        if (rst_n && s_act && !s_act_q) begin
            s_sh <= s_word; s_rx <= '0; s_first <= 1'b1;
        end else if (rst_n && s_act && SCLK !== s_sclk_q) begin
            if (SCLK !== s_mode[1]) begin
                if (!s_mode[0]) s_rx <= {s_rx[14:0], MOSI};
                else if (!s_first) s_sh <= s_sh << 1;
                s_first <= 1'b0;
            end else begin
                if (!s_mode[0]) s_sh <= s_sh << 1;
                else s_rx <= {s_rx[14:0], MOSI};
            end
        end
    end

    // Select monitor: only the expected select may ever be low
    logic [3:0] exp_ss = 4'hF;
    int ss_bad = 0;
    always @(negedge clk) begin
        if (rst_n && SS_n !== (busy ? exp_ss : 4'hF)) ss_bad <= ss_bad + 1;
    end

    task automatic start_xfer(input logic [1:0] m, input logic [1:0] sel,
                              input logic [15:0] wd, input logic [15:0] sw);
        s_mode = m; s_word = sw;
        exp_ss = 4'hF; exp_ss[sel] = 1'b0;
        mode = m; ss_sel = sel; wt_data = wd; wrt = 1'b1; t0 = cyc;
        sb_q.push_back(sw);
        @(negedge clk);
        wrt = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) begin lat = cyc - t0; break; end
            @(negedge clk);
        end
    endtask

    task automatic goto_cycle(input int c);
        for (int i = 0; i < 400; i++) begin
            if (cyc - t0 >= c) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (SS_n !== 4'hF) begin bad++; $display("FAIL rst_ss got=%b want=1111", SS_n); end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL rst_sclk got=%b want=1", SCLK); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_flags busy=%b done=%b want 0 0", busy, done); end
        total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL rst_rd got=%h want=0000", rd_data); end
        total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%b want=0", MOSI); end
        total++; if (SS_n2 !== 3'b111 || busy2 !== 1'b0) begin bad++; $display("FAIL rst_dut2 ss=%b busy=%b want 111 0", SS_n2, busy2); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode3();
        int lat; logic [15:0] e;
        start_xfer(2'b11, 2'd2, 16'hA5C3, 16'h3C5A);
        total++; if (busy !== 1'b1 || SS_n !== 4'b1011) begin bad++; $display("FAIL m3_start busy=%b ss=%b want 1 1011", busy, SS_n); end
        wait_done(lat);
        total++; if (lat != 265) begin bad++; $display("FAIL m3_latency got=%0d want=265", lat); end
        e = sb_q.pop_front();
        total++; if (rd_data !== e) begin bad++; $display("FAIL m3_rd got=%h want=%h", rd_data, e); end
        total++; if (s_rx !== 16'hA5C3) begin bad++; $display("FAIL m3_mosi got=%h want=a5c3", s_rx); end
        total++; if (SCLK !== 1'b1 || busy !== 1'b0 || SS_n !== 4'hF) begin bad++; $display("FAIL m3_end sclk=%b busy=%b ss=%b want 1 0 1111", SCLK, busy, SS_n); end
    endtask

    task automatic test_modes012();
        int lat; logic [15:0] e; logic [15:0] sw; logic [1:0] m;
        for (int k = 0; k < 3; k++) begin
            m = 2'(k);
            sw = 16'h4E21 ^ {m, 14'h0} ^ 16'(k);
            start_xfer(m, 2'd3, 16'h8001, sw);
            total++; if (SS_n !== 4'b0111 || MOSI !== 1'b1 || SCLK !== m[1]) begin bad++; $display("FAIL mode%0d_start ss=%b mosi=%b sclk=%b want 0111 1 %b", k, SS_n, MOSI, SCLK, m[1]); end
            wait_done(lat);
            total++; if (lat != 265) begin bad++; $display("FAIL mode%0d_latency got=%0d want=265", k, lat); end
            e = sb_q.pop_front();
            total++; if (rd_data !== e) begin bad++; $display("FAIL mode%0d_rd got=%h want=%h", k, rd_data, e); end
            total++; if (s_rx !== 16'h8001) begin bad++; $display("FAIL mode%0d_mosi got=%h want=8001", k, s_rx); end
            total++; if (SCLK !== m[1]) begin bad++; $display("FAIL mode%0d_idle got=%b want=%b", k, SCLK, m[1]); end
        end
        total++; if (ss_bad != 0) begin bad++; $display("FAIL ss_onehot stray_cycles=%0d want=0", ss_bad); end
    endtask

    task automatic test_ignore_wrt();
        int lat; logic [15:0] e;
        start_xfer(2'b11, 2'd2, 16'hA5C3, 16'h0F0F);
        goto_cycle(50);
        wrt = 1'b1; wt_data = 16'hFFFF; mode = 2'b00; ss_sel = 2'd3;
        @(negedge clk);
        wrt = 1'b0; wt_data = 16'h0000; mode = 2'b01;
        wait_done(lat);
        total++; if (lat != 265) begin bad++; $display("FAIL ign_latency got=%0d want=265", lat); end
        e = sb_q.pop_front();
        total++; if (rd_data !== e) begin bad++; $display("FAIL ign_rd got=%h want=%h", rd_data, e); end
        total++; if (s_rx !== 16'hA5C3) begin bad++; $display("FAIL ign_mosi got=%h want=a5c3", s_rx); end
        total++; if (ss_bad != 0) begin bad++; $display("FAIL ign_ss stray_cycles=%0d want=0", ss_bad); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] e;
        start_xfer(2'b01, 2'd1, 16'h1357, 16'hC0DE);
        goto_cycle(264);
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_264 done=%b busy=%b want 0 1", done, busy); end
        wrt = 1'b1; wt_data = 16'hDEAD;
        @(negedge clk);
        wrt = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_265 done=%b busy=%b want 1 0", done, busy); end
        e = sb_q.pop_front();
        total++; if (rd_data !== e) begin bad++; $display("FAIL b2b_rd1 got=%h want=%h", rd_data, e); end
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_late_wrt done=%b busy=%b want 1 0", done, busy); end
        start_xfer(2'b00, 2'd0, 16'h00FF, 16'hFF00);
        total++; if (done !== 1'b0 || busy !== 1'b1 || SS_n !== 4'b1110) begin bad++; $display("FAIL b2b_restart done=%b busy=%b ss=%b want 0 1 1110", done, busy, SS_n); end
        wait_done(lat);
        total++; if (lat != 265) begin bad++; $display("FAIL b2b_latency got=%0d want=265", lat); end
        e = sb_q.pop_front();
        total++; if (rd_data !== e || s_rx !== 16'h00FF) begin bad++; $display("FAIL b2b_rd2 got=%h/%h want=%h/00ff", rd_data, s_rx, e); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] e;
        start_xfer(2'b11, 2'd2, 16'h1111, 16'h2222);
        goto_cycle(100);
        rst_n = 1'b0;
        #1;
        total++; if (SS_n !== 4'hF || SCLK !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid ss=%b sclk=%b done=%b busy=%b want 1111 1 0 0", SS_n, SCLK, done, busy); end
        total++; if (rd_data !== 16'h0 || MOSI !== 1'b0) begin bad++; $display("FAIL rmid_data rd=%h mosi=%b want 0000 0", rd_data, MOSI); end
        sb_q.delete();
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        start_xfer(2'b11, 2'd3, 16'hABCD, 16'h4321);
        wait_done(lat);
        total++; if (lat != 265) begin bad++; $display("FAIL rmid_latency got=%0d want=265", lat); end
        e = sb_q.pop_front();
        total++; if (rd_data !== e || s_rx !== 16'hABCD) begin bad++; $display("FAIL rmid_rd got=%h/%h want=%h/abcd", rd_data, s_rx, e); end
    endtask

    task automatic test_small();
        int lat; int t2; int lows; logic [7:0] e;
        for (int k = 0; k < 2; k++) begin
            mode2 = (k == 0) ? 2'b00 : 2'b01; sel2 = (k == 0) ? 2'd0 : 2'd3;
            wt2 = (k == 0) ? 8'h9C : 8'h35;
            sb2_q.push_back(wt2);
            wrt2 = 1'b1; t2 = cyc;
            @(negedge clk);
            wrt2 = 1'b0;
            total++; if (busy2 !== 1'b1 || SS_n2 !== ((k == 0) ? 3'b110 : 3'b111)) begin bad++; $display("FAIL small%0d_start busy=%b ss=%b", k, busy2, SS_n2); end
            lat = -1; lows = 0;
            for (int i = 0; i < 200; i++) begin
                if (done2 === 1'b1) begin lat = cyc - t2; break; end
                if (k == 1 && SS_n2 !== 3'b111) lows++;
                @(negedge clk);
            end
            total++; if (lat != 35) begin bad++; $display("FAIL small%0d_latency got=%0d want=35", k, lat); end
            e = sb2_q.pop_front();
            total++; if (rd2 !== e) begin bad++; $display("FAIL small%0d_rd got=%h want=%h", k, rd2, e); end
            total++; if (lows != 0) begin bad++; $display("FAIL small%0d_ss_oob low_cycles=%0d want=0", k, lows); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode3();
        test_modes012();
        test_ignore_wrt();
        test_back_to_back();
        test_reset_mid();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_mnrch_param.md
SPI_MNRCH_PARAM -- requirements
Module: spi_mnrch_param

Interface
REQ-001 Parameter DATA_W, 16, bits per transaction (legal 8..32).
REQ-002 Parameter CLK_DIV, 16, clk cycles per SCLK period (even, legal 4..256); H = CLK_DIV/2.
REQ-003 Parameter NUM_SS, 1, number of serf selects (legal 1..8).
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wrt  input  1  one-cycle start strobe.
REQ-007 wt_data  input  DATA_W  data shifted out MSB first.
REQ-008 mode  input  2  {CPOL,CPHA}; latched on accepted wrt.
REQ-009 ss_sel  input  $clog2(NUM_SS) (min 1)  serf index; latched on accepted wrt.
REQ-010 MISO  input  1  serf data in.
REQ-011 SCLK  output  1  serial clock.
REQ-012 MOSI  output  1  monarch data out; equals shift-register MSB.
REQ-013 SS_n  output  NUM_SS  active-low selects, one-hot-low while active.
REQ-014 busy  output  1  high from cycle after accepted wrt until done sets.
REQ-015 done  output  1  set at transaction end; held until next accepted wrt.
REQ-016 rd_data  output  DATA_W  received word; valid while done high.

Function
REQ-017 FSM states IDLE, FRONT, SHFT, BACK; wrt accepted only in IDLE; wrt in any other state ignored.
REQ-018 Accepted wrt (cycle 0): load wt_data into shift register, latch mode/ss_sel, clear done, go FRONT; SS_n[ss_sel] low and busy high from cycle 1.
REQ-019 SCLK idles at latched CPOL; SCLK edges occur at cycles 1+H*k, k=1..2*DATA_W; SHFT spans these edges.
REQ-020 Odd k = leading edge, even k = trailing edge.
REQ-021 CPHA=0: MOSI valid from cycle 1; sample on leading edges; shift on trailing edges except the last.
REQ-022 CPHA=1: shift on leading edges except the first; sample on trailing edges.
REQ-023 MISO captured into shift-register LSB on the clk cycle immediately after each sampling edge; shift moves left.
REQ-024 After edge 2*DATA_W, BACK holds H cycles; at cycle 1+H*(2*DATA_W+1) SS_n all high, busy low, done high, return IDLE.
REQ-025 Example: DATA_W=16, CLK_DIV=16 -> last edge cycle 257, done at cycle 265.
REQ-026 ss_sel >= NUM_SS: transaction runs normally; all SS_n stay high.
REQ-027 wrt in same cycle done is being set is ignored; wrt in IDLE while done high is accepted and clears done next cycle.
REQ-028 mode/ss_sel/wt_data changes while busy have no effect.
REQ-029 Edge counter width $clog2(2*DATA_W+1); divider counter width $clog2(CLK_DIV); no wrap mid-transaction.

Reset
REQ-030 rst_n low: state IDLE, SS_n all 1, SCLK 1 (latched mode resets to 2'b11), busy 0, done 0, rd_data 0, MOSI 0.
REQ-031 Reset mid-transaction aborts immediately with REQ-030 values; no partial done.

Structure
REQ-032 Package spi_pkg holds spi_mode_t ({CPOL,CPHA}) and spi_state_t enum; shared with serf-side models.
REQ-033 Sub-module spi_sclk_gen holds the divider and edge counter; outputs SCLK, lead/trail strobes, last_edge.
REQ-034 Top holds FSM, shift register, SS decode, done/busy flops.

Verification
REQ-035 Mode 3, DATA_W=16, CLK_DIV=16, wt_data=16'hA5C3, serf loopback returns 16'h3C5A -> rd_data=16'h3C5A, done at cycle 265, SCLK idle high.
REQ-036 Modes 0,1,2 each with wt_data=16'h8001, serf model per mode -> correct MOSI bit on each sampling edge, rd_data matches serf word.
REQ-037 NUM_SS=4, ss_sel=2 -> SS_n=4'b1011 during transaction; ss_sel=3 next transfer -> 4'b0111; other bits never low.
REQ-038 Second wrt at cycle 50 of active transfer -> ignored, rd_data and timing unchanged.
REQ-039 rst_n low at cycle 100 of transfer -> SS_n all 1, SCLK 1, done 0 same cycle; new wrt after release completes normally.
REQ-040 DATA_W=8, CLK_DIV=4 -> last edge cycle 33, done at cycle 35, 8 bits captured.
